signed_nrda_div: RTL and testbench

Sequential signed integer divider using the non-restoring division algorithm (NRDA). It accepts a WIDTH-bit two's-complement dividend and divisor and produces a truncated quotient and a remainder, one bit per clock. It sits beside the datapath as a multi-cycle functional unit with a start/done handshake, and its results are held stable until the next operation.

---
 rtl/signed_nrda_div.sv | 139 +++++++++++++
 tb/tb_signed_nrda_div.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/signed_nrda_div.sv
// Sequential signed divider (non-restoring, one quotient bit per clock, start/done handshake).
// Define NRDA_DIV_EARLY_OUT_EN to finish divide-by-zero and -2^(W-1)/-1 in two cycles.
module signed_nrda_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix
`ifdef NRDA_DIV_EARLY_OUT_EN
    , StSpec
`endif
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;       // |x|, shifted out MSB first
  logic [WIDTH-1:0] d_q;       // |y|
  logic [WIDTH:0]   p_q;       // signed partial remainder
  logic [WIDTH-1:0] qs_q;      // quotient bits (~sign of each new remainder)
  logic             neg_q_q;
  logic             neg_r_q;
  logic             zero_q;
  logic             phase_q;

  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH:0]   p_sh, p_step;
  logic [WIDTH-1:0] res_q, res_r;

  assign x_abs = x[WIDTH-1] ? -x : x;
  assign y_abs = y[WIDTH-1] ? -y : y;

  always_comb begin
    p_sh   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    p_step = p_q[WIDTH] ? p_sh + {1'b0, d_q} : p_sh - {1'b0, d_q};
  end

  // With bits taken as ~new_sign, the +/-1 digit conversion plus the final -1 correction
  // collapses to the raw bit vector, so qs_q is already the magnitude of the quotient.
  always_comb begin
    res_q = zero_q ? '1 : (neg_q_q ? -qs_q : qs_q);
    res_r = neg_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  end

`ifdef NRDA_DIV_EARLY_OUT_EN
  logic special;
  assign special = (y == '0) || ((x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == '1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      d_q         <= '0;
      p_q         <= '0;
      qs_q        <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      zero_q      <= 1'b0;
      phase_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= x_abs;
            d_q     <= y_abs;
            p_q     <= '0;
            qs_q    <= '0;
            neg_q_q <= x[WIDTH-1] ^ y[WIDTH-1];
            neg_r_q <= x[WIDTH-1];
            zero_q  <= (y == '0);
            cnt_q   <= CW'(WIDTH - 1);
            phase_q <= 1'b0;
            busy    <= 1'b1;
`ifdef NRDA_DIV_EARLY_OUT_EN
            if (special) begin
              // Preload what the iterations would have produced.
              p_q     <= (y == '0) ? {1'b0, x_abs} : '0;
              qs_q    <= x_abs;
              state_q <= StSpec;
            end else begin
              state_q <= StIter;
            end
`else
            state_q <= StIter;
`endif
          end
        end
        StIter: begin
          a_q  <= a_q << 1;
          p_q  <= p_step;
          qs_q <= {qs_q[WIDTH-2:0], ~p_step[WIDTH]};
          if (cnt_q == '0) state_q <= StFix;
          else             cnt_q   <= cnt_q - 1'b1;
        end
`ifdef NRDA_DIV_EARLY_OUT_EN
        StFix, StSpec: begin
`else
        StFix: begin
`endif
          if (!phase_q) begin
            phase_q <= 1'b1;
            if (state_q == StFix && p_q[WIDTH]) p_q <= p_q + {1'b0, d_q};
          end else begin
            q           <= res_q;
            r           <= res_r;
            div_by_zero <= zero_q;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_nrda_div.sv
// Scoreboard bench for signed_nrda_div: driver pushes expected results, monitor checks on done.
module tb_signed_nrda_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         busy, done, div_by_zero;
  logic [W-1:0] q, r;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    longint       t0;
  } exp_t;

  exp_t sb[$];

  signed_nrda_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef NRDA_DIV_EARLY_OUT_EN
    if (b == 32'h0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
    return W + 2;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("q", q, e.q);
        check("r", r, e.r);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
        check("latency", 32'(($time - 1 - e.t0) / 10), 32'(e.lat));
        check("busy_at_done", {31'b0, busy}, 32'h0);
      end
    end
  end

  // Called between edges with the DUT idle or presenting done; returns on the done cycle.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic ez, input bit glitch);
    exp_t e;
    bit   got;
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    e.q = eq; e.r = er; e.z = ez; e.lat = exp_lat(a, b); e.t0 = $time;
    sb.push_back(e);
    #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    got = 1'b0;
    for (int i = 0; i < W + 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (glitch && i == 4) begin
        start = 1'b1; x = 32'd1; y = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL timeout: got no done expected one for x=%h y=%h", a, b);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_q", q, 32'h0);
    check("rst_r", r, 32'h0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd1436,  32'd135,  32'd10,  32'd86,  1'b0, 1'b0);
    run(-32'd1436, 32'd135,  -32'd10, -32'd86, 1'b0, 1'b0);
    run(32'd1436,  -32'd135, -32'd10, 32'd86,  1'b0, 1'b0);
    run(-32'd1436, -32'd135, 32'd10,  -32'd86, 1'b0, 1'b0);
    run(32'd7,     32'd0,    32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0);
    run(-32'd7,    32'd0,    32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
    run(32'h8000_0000, 32'd2, 32'hC000_0000, 32'h0, 1'b0, 1'b0);
    run(32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0);
    run(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0);
    run(32'd0,     32'd5,    32'd0,   32'd0,   1'b0, 1'b0);
    run(-32'd1,    32'd2,    32'd0,   -32'd1,  1'b0, 1'b0);
    run(32'd5,     32'd7,    32'd0,   32'd5,   1'b0, 1'b0);
    // start pulsed while busy must not disturb the operation in flight
    run(32'd100,   32'd7,    32'd14,  32'd2,   1'b0, 1'b1);
    run(-32'd100,  32'd7,    -32'd14, -32'd2,  1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i[0]) rb = -rb;
      if (rb == 32'h0) rb = 32'd3;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      rq = $signed(ra) / $signed(rb);
      rr = $signed(ra) % $signed(rb);
      run(ra, rb, rq, rr, 1'b0, 1'b0);
    end

    // Reset in the middle of an iteration: outputs clear and no done follows.
    x = 32'd1000; y = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_q", q, 32'h0);
    check("midrst_r", r, 32'h0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    run(32'd1436, 32'd135, 32'd10, 32'd86, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
